// File: rtl/phaethon_exec_unit.sv
// phaethon_exec_unit: multi-cycle fetch/decode/execute sequencer, one req/ack RAM port.
// Optional retire counter: define PHAETHON_RETIRE_CNT_EN to add the retired[31:0] output.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   ramIn, readAck, writeAck   RAM read data and completion acks
//   ramAddress, ramOut         RAM address and write data (held until ack)
//   readReq, writeReq          one-cycle request pulses
//   ipointer, opCode           instruction pointer, current opcode
//   halted, debug              halt flag, value written by setdebug
//   retired                    EXEC count (PHAETHON_RETIRE_CNT_EN only)
module phaethon_exec_unit #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_COUNT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ramIn,
  input  logic              readAck,
  input  logic              writeAck,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [DATA_W-1:0] ramOut,
  output logic              readReq,
  output logic              writeReq,
  output logic [ADDR_W-1:0] ipointer,
  output logic [7:0]        opCode,
  output logic              halted,
  output logic [DATA_W-1:0] debug
`ifdef PHAETHON_RETIRE_CNT_EN
  ,
  output logic [31:0]       retired
`endif
);

  localparam int IDX_W = $clog2(REG_COUNT);
  localparam logic [IDX_W-1:0] FR = IDX_W'(REG_COUNT - 1);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_FWAIT  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_IMM    = 4'd3;
  localparam logic [3:0] S_IWAIT  = 4'd4;
  localparam logic [3:0] S_MEM    = 4'd5;
  localparam logic [3:0] S_MWAIT  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_HALT   = 4'd8;

  logic [3:0] state;
  logic [IDX_W-1:0] idxA, idxB, idxC;
  logic [DATA_W-1:0] valA, valB, valC;
  logic [DATA_W-1:0] imm, loadData;
  logic [REG_COUNT-1:0][DATA_W-1:0] regs;

  logic hasImm, memImm, memReg;
  logic isLoad, isStore;

  always_comb begin
    hasImm = opCode inside {8'd1, 8'd2, 8'd4, 8'd6,
                            8'd7, 8'd8, 8'd9};
    memImm = opCode inside {8'd2, 8'd4};
    memReg = opCode inside {8'd17, 8'd18};
    isLoad = opCode inside {8'd2, 8'd17};
    isStore = opCode inside {8'd4, 8'd18};
  end

  logic wrEn;
  logic [IDX_W-1:0] wrIdx;
  logic [DATA_W-1:0] wrData;
  logic [ADDR_W-1:0] seqIp, nextIp;

  assign seqIp = ipointer
    + (hasImm ? ADDR_W'(8) : ADDR_W'(4));

  always_comb begin
    wrEn = 1'b0;
    wrIdx = idxA;
    wrData = '0;
    nextIp = seqIp;
    unique case (opCode)
      8'd1: begin
        wrEn = 1'b1;
        wrData = imm;
      end
      8'd2, 8'd17: begin
        wrEn = 1'b1;
        wrData = loadData;
      end
      8'd3: begin
        wrEn = 1'b1;
        wrData = valB;
      end
      8'd5: begin
        wrEn = 1'b1;
        wrIdx = FR;
        wrData = DATA_W'({valA > valB,
                          valA < valB,
                          valA == valB});
      end
      8'd6: nextIp = ADDR_W'(imm);
      8'd7: if (regs[FR][0]) nextIp = ADDR_W'(imm);
      8'd8: if (regs[FR][1]) nextIp = ADDR_W'(imm);
      8'd9: if (regs[FR][2]) nextIp = ADDR_W'(imm);
      8'd10: begin
        wrEn = 1'b1;
        wrData = valB + valC;
      end
      8'd11: begin
        wrEn = 1'b1;
        wrData = valB - valC;
      end
      8'd12: begin
        wrEn = 1'b1;
        wrData = valB & valC;
      end
      8'd13: begin
        wrEn = 1'b1;
        wrData = valB | valC;
      end
      8'd14: begin
        wrEn = 1'b1;
        wrData = valB ^ valC;
      end
      8'd15: begin
        wrEn = 1'b1;
        wrData = valB << valC[4:0];
      end
      8'd16: begin
        wrEn = 1'b1;
        wrData = valB >> valC[4:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ipointer <= '0;
      opCode <= '0;
      halted <= 1'b0;
      debug <= '0;
      idxA <= '0;
      idxB <= '0;
      idxC <= '0;
      valA <= '0;
      valB <= '0;
      valC <= '0;
      imm <= '0;
      loadData <= '0;
      regs <= '0;
    end else begin
      unique case (state)
        S_FETCH: state <= S_FWAIT;
        S_FWAIT: begin
          if (readAck) begin
            opCode <= ramIn[7:0];
            idxA <= ramIn[8+:IDX_W];
            idxB <= ramIn[16+:IDX_W];
            idxC <= ramIn[24+:IDX_W];
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          // Operands are snapshotted here so a write
          // to a source register sees the old value.
          valA <= regs[idxA];
          valB <= regs[idxB];
          valC <= regs[idxC];
          if (hasImm) state <= S_IMM;
          else if (memReg) state <= S_MEM;
          else state <= S_EXEC;
        end
        S_IMM: state <= S_IWAIT;
        S_IWAIT: begin
          if (readAck) begin
            imm <= ramIn;
            state <= memImm ? S_MEM : S_EXEC;
          end
        end
        S_MEM: state <= S_MWAIT;
        S_MWAIT: begin
          if (isLoad ? readAck : writeAck) begin
            if (isLoad) loadData <= ramIn;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (wrEn) regs[wrIdx] <= wrData;
          if (opCode == 8'd30) debug <= valA;
          if (opCode == 8'd31) begin
            halted <= 1'b1;
            state <= S_HALT;
          end else begin
            ipointer <= nextIp;
            state <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] storeData;

  assign memAddr = memImm ? ADDR_W'(imm)
                          : ADDR_W'(valB);
  assign storeData = (opCode == 8'd4) ? valB : valC;

  always_comb begin
    ramAddress = '0;
    ramOut = '0;
    unique case (1'b1)
      (state == S_FETCH) || (state == S_FWAIT):
        ramAddress = ipointer;
      (state == S_IMM) || (state == S_IWAIT):
        ramAddress = ipointer + ADDR_W'(4);
      (state == S_MEM) || (state == S_MWAIT): begin
        ramAddress = memAddr;
        if (isStore) ramOut = storeData;
      end
      default: ;
    endcase
    // Requests are masked while reset is held so the
    // FETCH state entered by reset does not pulse early.
    readReq = !reset
      && ((state == S_FETCH) || (state == S_IMM)
          || ((state == S_MEM) && isLoad));
    writeReq = !reset && (state == S_MEM) && isStore;
  end

`ifdef PHAETHON_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) retired <= '0;
    else if (state == S_EXEC) retired <= retired + 32'd1;
  end
`endif

endmodule
